// File: rtl/bdg_pkg.sv
// ----------------------------------------------------------------------------
// bdg_pkg
// Shared definitions for the birth-date digit sequencer.
//   state_t             : sequencer FSM states
//   BIRTH_CODE_DEFAULT  : default packed-BCD code (digit 0 in the top nibble)
//   bcd_valid()         : true when a digit value is a legal BCD digit (0..9)
// ----------------------------------------------------------------------------
package bdg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] BIRTH_CODE_DEFAULT = 32'h19970728;

    function automatic logic bcd_valid(input logic [31:0] digit);
        return (digit <= 32'd9);
    endfunction

endpackage

// File: rtl/birth_digit_sequencer_if.sv
// ----------------------------------------------------------------------------
// birth_digit_sequencer_if
// Control, digit stream and random-access lookup signals of the sequencer.
//   master : controller / consumer side (drives start, stop, mode_loop,
//            dout_ready, sel_idx)
//   slave  : sequencer side (drives dout_*, busy, done, bcd_err, sel_digit)
// ----------------------------------------------------------------------------
interface birth_digit_sequencer_if #(
    parameter int DIGIT_W = 4,
    parameter int IDX_W   = 3
);
    logic               start;
    logic               stop;
    logic               mode_loop;
    logic               dout_ready;
    logic               dout_valid;
    logic [DIGIT_W-1:0] dout_digit;
    logic [IDX_W-1:0]   dout_index;
    logic               busy;
    logic               done;
    logic               bcd_err;
    logic [IDX_W-1:0]   sel_idx;
    logic [DIGIT_W-1:0] sel_digit;

    modport master (
        output start, stop, mode_loop, dout_ready, sel_idx,
        input  dout_valid, dout_digit, dout_index, busy, done, bcd_err, sel_digit
    );

    modport slave (
        input  start, stop, mode_loop, dout_ready, sel_idx,
        output dout_valid, dout_digit, dout_index, busy, done, bcd_err, sel_digit
    );
endinterface

// File: rtl/birth_digit_rom.sv
// ----------------------------------------------------------------------------
// birth_digit_rom
// Combinational index -> digit lookup into a packed code constant.
// Digit 0 is the most-significant field; out-of-range indices read as 0.
//   i_idx   : digit index
//   o_digit : selected digit
// ----------------------------------------------------------------------------
module birth_digit_rom #(
    parameter int                              NUM_DIGITS = 8,
    parameter int                              DIGIT_W    = 4,
    parameter int                              IDX_W      = 3,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]   CODE       = '0
) (
    input  logic [IDX_W-1:0]   i_idx,
    output logic [DIGIT_W-1:0] o_digit
);

    always_comb begin
        o_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_digit = CODE[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

endmodule

// File: rtl/birth_digit_sequencer.sv
// ----------------------------------------------------------------------------
// birth_digit_sequencer
// Streams the digits of CODE over a valid/ready interface, one-shot or
// looping, and offers a combinational random-access lookup of the same code.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of birth_digit_sequencer_if (control, stream, lookup)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; last digit/index held, valid low
//   ST_RUN  | presenting dout_digit/dout_index with valid high
//   ST_DONE | single cycle after a one-shot sequence, done pulse high
// ----------------------------------------------------------------------------
module birth_digit_sequencer
    import bdg_pkg::*;
#(
    parameter int                            NUM_DIGITS = 8,
    parameter int                            DIGIT_W    = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] CODE       = (NUM_DIGITS*DIGIT_W)'(BIRTH_CODE_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    birth_digit_sequencer_if.slave bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t             r_state;
    logic               r_loop;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_bcd_err;
    logic [IDX_W-1:0]   r_idx;
    logic [DIGIT_W-1:0] r_digit;

    logic               w_hs;
    logic               w_last;
    logic [IDX_W-1:0]   w_next_idx;
    logic [IDX_W-1:0]   w_rom_idx;
    logic [DIGIT_W-1:0] w_rom_digit;
    logic [DIGIT_W-1:0] w_sel_digit;

    assign w_hs       = r_valid & bus.dout_ready;
    assign w_last     = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_next_idx = w_last ? '0 : r_idx + IDX_W'(1);
    // The ROM looks up whichever digit gets loaded at the next edge:
    // digit 0 on a start from IDLE, the successor during RUN.
    assign w_rom_idx  = (r_state == ST_RUN) ? w_next_idx : '0;

    birth_digit_rom #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (DIGIT_W),
        .IDX_W      (IDX_W),
        .CODE       (CODE)
    ) u_rom_seq (
        .i_idx   (w_rom_idx),
        .o_digit (w_rom_digit)
    );

    birth_digit_rom #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (DIGIT_W),
        .IDX_W      (IDX_W),
        .CODE       (CODE)
    ) u_rom_sel (
        .i_idx   (bus.sel_idx),
        .o_digit (w_sel_digit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_loop    <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd_err <= 1'b0;
            r_idx     <= '0;
            r_digit   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state   <= ST_RUN;
                        r_loop    <= bus.mode_loop;
                        r_bcd_err <= 1'b0;
                        r_idx     <= '0;
                        r_digit   <= w_rom_digit;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // An accepted digit is checked even when stop aborts
                    // in the same cycle.
                    if (w_hs && !bcd_valid(32'(r_digit))) begin
                        r_bcd_err <= 1'b1;
                    end
                    if (bus.stop) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_hs) begin
                        if (w_last && !r_loop) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_digit <= w_rom_digit;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout_valid = r_valid;
    assign bus.dout_digit = r_digit;
    assign bus.dout_index = r_idx;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.bcd_err    = r_bcd_err;
    assign bus.sel_digit  = w_sel_digit;

endmodule

// File: tb/tb_birth_digit_sequencer.sv
module tb_birth_digit_sequencer;

    localparam int          ND     = 8;
    localparam logic [31:0] CODE_A = 32'h19970728;
    localparam logic [31:0] CODE_B = 32'h1997A728;
    localparam logic [23:0] CODE_C = 24'h970728;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    birth_digit_sequencer_if #(.DIGIT_W(4), .IDX_W(3)) ifa ();
    birth_digit_sequencer_if #(.DIGIT_W(4), .IDX_W(3)) ifb ();
    birth_digit_sequencer_if #(.DIGIT_W(4), .IDX_W(3)) ifc ();

    birth_digit_sequencer #(.NUM_DIGITS(8), .DIGIT_W(4), .CODE(CODE_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    birth_digit_sequencer #(.NUM_DIGITS(8), .DIGIT_W(4), .CODE(CODE_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));
    birth_digit_sequencer #(.NUM_DIGITS(6), .DIGIT_W(4), .CODE(CODE_C)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc));

    // Reference: digit i of an nd-digit packed code, most significant first.
    function automatic logic [3:0] ref_digit(input logic [63:0] code, input int nd, input int i);
        logic [63:0] sh;
        if (i < 0 || i >= nd) return 4'd0;
        sh = code >> ((nd - 1 - i) * 4);
        return sh[3:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one sequence on dut_a starting from IDLE at a falling edge.
    // n_stop = 0: one-shot to completion; otherwise stop after n_stop accepted
    // digits, either in the same cycle as that handshake or in the next cycle
    // with ready low.
    task automatic run_seq(input bit loop_m, input bit rnd_ready, input int n_stop, input bit stop_on_hs);
        int         acc          = 0;
        int         cyc          = 0;
        int         since_stop   = -1;
        bit         held         = 1'b0;
        bit         stop_pending = 1'b0;
        logic [3:0] hd           = '0;
        logic [2:0] hi           = '0;
        ifa.mode_loop  = loop_m;
        ifa.start      = 1'b1;
        ifa.dout_ready = 1'b0;
        @(negedge clk);
        ifa.start     = 1'b0;
        ifa.mode_loop = ~loop_m;
        chk("busy_on_start", 32'(ifa.busy), 32'd1);
        chk("first_index", 32'(ifa.dout_index), 32'd0);
        while (ifa.dout_valid && cyc < 200) begin
            ifa.stop       = 1'b0;
            ifa.start      = 1'($urandom_range(0, 1));
            ifa.dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stop_pending) begin
                ifa.stop       = 1'b1;
                ifa.dout_ready = 1'b0;
                stop_pending   = 1'b0;
                since_stop     = 0;
            end
            if (held) begin
                chk("hold_digit", 32'(ifa.dout_digit), 32'(hd));
                chk("hold_index", 32'(ifa.dout_index), 32'(hi));
            end
            chk("done_low_in_run", 32'(ifa.done), 32'd0);
            if (ifa.dout_ready) begin
                chk("digit", 32'(ifa.dout_digit), 32'(ref_digit(CODE_A, ND, acc % ND)));
                chk("index", 32'(ifa.dout_index), 32'(acc % ND));
                acc++;
                held = 1'b0;
                if (n_stop != 0 && acc == n_stop) begin
                    if (stop_on_hs) begin
                        ifa.stop   = 1'b1;
                        since_stop = 0;
                    end else begin
                        stop_pending = 1'b1;
                    end
                end
            end else begin
                held = 1'b1;
                hd   = ifa.dout_digit;
                hi   = ifa.dout_index;
            end
            @(negedge clk);
            cyc++;
            if (since_stop >= 0) since_stop++;
        end
        ifa.stop       = 1'b0;
        ifa.start      = 1'b0;
        ifa.dout_ready = 1'b0;
        if (cyc >= 200) chk("stream_timeout", 32'd0, 32'd1);
        if (n_stop == 0) begin
            chk("accepted_count", 32'(acc), 32'(ND));
            chk("done_pulse", 32'(ifa.done), 32'd1);
            chk("busy_in_done", 32'(ifa.busy), 32'd0);
            ifa.start = 1'b1;   // must be ignored in DONE
            @(negedge clk);
            ifa.start = 1'b0;
            chk("done_one_cycle", 32'(ifa.done), 32'd0);
            chk("start_ignored_in_done", 32'(ifa.busy), 32'd0);
        end else begin
            chk("accepted_count", 32'(acc), 32'(n_stop));
            chk("stop_latency", 32'(since_stop), 32'd1);
            chk("busy_after_stop", 32'(ifa.busy), 32'd0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("no_done_after_stop", 32'(ifa.done), 32'd0);
            end
        end
        chk("idle_valid", 32'(ifa.dout_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int   acc;
        int   cyc;
        logic err_exp;
        logic [3:0] d;

        ifa.start = 0; ifa.stop = 0; ifa.mode_loop = 0; ifa.dout_ready = 0; ifa.sel_idx = '0;
        ifb.start = 0; ifb.stop = 0; ifb.mode_loop = 0; ifb.dout_ready = 0; ifb.sel_idx = '0;
        ifc.start = 0; ifc.stop = 0; ifc.mode_loop = 0; ifc.dout_ready = 0; ifc.sel_idx = '0;

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(ifa.dout_valid), 32'd0);
        chk("rst_digit", 32'(ifa.dout_digit), 32'd0);
        chk("rst_index", 32'(ifa.dout_index), 32'd0);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_done", 32'(ifa.done), 32'd0);
        chk("rst_bcd_err", 32'(ifa.bcd_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // one-shot, ready tied high, then with random ready
        run_seq(1'b0, 1'b0, 0, 1'b0);
        for (int r = 0; r < 3; r++) run_seq(1'b0, 1'b1, 0, 1'b0);

        // looping: stop with handshake, then stop while not ready
        run_seq(1'b1, 1'b0, 20, 1'b1);
        run_seq(1'b1, 1'b1, 11, 1'b0);
        run_seq(1'b1, 1'b1, 13, 1'b1);

        // asynchronous reset mid-sequence at index 3 with ready low
        ifa.mode_loop = 1'b0; ifa.start = 1'b1; ifa.dout_ready = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (3) @(negedge clk);
        ifa.dout_ready = 1'b0;
        chk("pre_reset_index", 32'(ifa.dout_index), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ifa.dout_valid), 32'd0);
        chk("async_rst_digit", 32'(ifa.dout_digit), 32'd0);
        chk("async_rst_index", 32'(ifa.dout_index), 32'd0);
        chk("async_rst_busy", 32'(ifa.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_resume_after_rst", 32'(ifa.dout_valid), 32'd0);
        run_seq(1'b0, 1'b0, 0, 1'b0);

        // bcd_err on a code with a non-BCD digit at index 4
        ifb.mode_loop = 1'b0; ifb.start = 1'b1; ifb.dout_ready = 1'b0;
        @(negedge clk);
        ifb.start = 1'b0;
        acc = 0; cyc = 0; err_exp = 1'b0;
        while (ifb.dout_valid && cyc < 100) begin
            ifb.dout_ready = 1'($urandom_range(0, 1));
            chk("bcd_err_track", 32'(ifb.bcd_err), 32'(err_exp));
            if (ifb.dout_ready) begin
                d = ref_digit(CODE_B, ND, acc);
                chk("b_digit", 32'(ifb.dout_digit), 32'(d));
                if (d > 4'd9) err_exp = 1'b1;
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        ifb.dout_ready = 1'b0;
        if (cyc >= 100) chk("b_timeout", 32'd0, 32'd1);
        chk("b_count", 32'(acc), 32'(ND));
        chk("b_done", 32'(ifb.done), 32'd1);
        chk("b_err_through_done", 32'(ifb.bcd_err), 32'd1);
        @(negedge clk);
        chk("b_err_sticky_idle", 32'(ifb.bcd_err), 32'd1);
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        chk("b_err_cleared", 32'(ifb.bcd_err), 32'd0);
        chk("b_restart_digit", 32'(ifb.dout_digit), 32'(ref_digit(CODE_B, ND, 0)));
        ifb.stop = 1'b1;
        @(negedge clk);
        ifb.stop = 1'b0;
        chk("b_stopped", 32'(ifb.dout_valid), 32'd0);

        // random-access lookup, including out-of-range on the 6-digit code
        for (int i = 0; i < 8; i++) begin
            ifa.sel_idx = 3'(i);
            ifc.sel_idx = 3'(i);
            #1;
            chk("sel_a", 32'(ifa.sel_digit), 32'(ref_digit(CODE_A, 8, i)));
            chk("sel_c", 32'(ifc.sel_digit), 32'(ref_digit(64'(CODE_C), 6, i)));
        end
        for (int k = 0; k < 8; k++) begin
            int r;
            r = int'($urandom_range(0, 7));
            ifb.sel_idx = 3'(r);
            #1;
            chk("sel_b", 32'(ifb.sel_digit), 32'(ref_digit(CODE_B, 8, r)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
